// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader that fills the MIPS core's memory.
// Optional checksum support is compiled in with BOOT_CHECKSUM_EN.
package boot_pkg;
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;
endpackage

// File: rtl/byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word.
// Flags the accept that completes the word.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [1:0]  r_cnt;
    logic [23:0] r_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Shift register only holds the three older bytes; the newest arrives on i_byte.
    always_ff @(posedge clk) begin
        if (i_accept) begin
            r_sr <= o_word[31:8];
        end
    end

    assign o_word      = {i_byte, r_sr};
    assign o_word_full = i_accept && (r_cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/boot_loader.sv
// Streams a byte image into memory as sequential 32-bit words, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing little-endian word sum before release.
module boot_loader
    import boot_pkg::*;
#(
    parameter int WORD_COUNT = 16,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int            IW       = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_COUNT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_widx;
    logic          r_byte_ready;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wd;
    logic          r_cpu_rstn;
    logic          r_busy;
    logic          r_done;
    logic          w_accept;
    logic          w_start;
    logic          w_word_full;
    logic [31:0]   w_word;

    assign w_accept = byte_valid && r_byte_ready;
    assign w_start  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

    byte_packer u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .i_clr       (w_start),
        .i_accept    (w_accept),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
        end else if (w_word_full && (r_state == COLLECT)) begin
            r_sum <= r_sum + w_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_next == ERROR);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = COLLECT;
            COLLECT: if (w_word_full) w_next = WRITE;
            WRITE: begin
                if (r_widx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = DONE;
`endif
                end else begin
                    w_next = COLLECT;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK:   if (w_word_full) w_next = (w_word == r_sum) ? DONE : ERROR;
            ERROR:   if (start) w_next = COLLECT;
`endif
            DONE:    if (start) w_next = COLLECT;
            default: w_next = IDLE;
        endcase
    end

    // Every control output is registered from the next state, so it is valid in the state it describes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_rstn   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == COLLECT) || (w_next == CHECK);
            r_mem_we     <= (w_next == WRITE);
            r_busy       <= (w_next == COLLECT) || (w_next == WRITE) || (w_next == CHECK);
            r_done       <= (w_next == DONE);
            r_cpu_rstn   <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_widx     <= '0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else begin
            if (w_start) begin
                r_widx <= '0;
            end else if ((r_state == WRITE) && (r_widx != LAST_IDX)) begin
                r_widx <= r_widx + IW'(1);
            end
            if (w_next == WRITE) begin
                r_mem_addr <= AW'(r_widx) << WORD_ADDR_SHIFT;
                r_mem_wd   <= w_word;
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wd     = r_mem_wd;
    assign cpu_rstn   = r_cpu_rstn;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule
